stream_demux2: RTL and testbench

Single-input, dual-output stream router with packet-level routing lock. It is the steering counterpart of the two-input selector: where the selector picks `a` or `b` onto one output, this block takes one valid/ready stream and sends each packet to port A or port B. The rule is the same `{sel_b1, sel_b2} == 2'b11` test: 11 selects B, anything else selects A. It sits between a packet source and two downstream consumers, and registers each output for timing isolation.

---
 rtl/stream_demux2_pkg.sv | 11 +
 rtl/stream_demux2_if.sv | 36 +++
 rtl/stream_demux2_out_stage.sv | 37 +++
 rtl/stream_demux2.sv | 91 +++++++++
 tb/tb_stream_demux2.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux2_pkg.sv
// rtl/stream_demux2_pkg.sv - shared types and constants for the stream_demux2 router
// Purpose: route FSM state encoding and the select code that steers a packet to port B.
// Ports: none (package).
package stream_demux_pkg;

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} route_state_e;

  // {sel_b1, sel_b2} equal to this code routes the packet to B; anything else goes to A.
  localparam logic [1:0] SEL_B = 2'b11;

endpackage

// File: rtl/stream_demux2_if.sv
// rtl/stream_demux2_if.sv - stream bundle between the packet source, the router and its two consumers
// Purpose: groups the input stream, route selects, both output streams, counters and busy.
// Ports: master = source/consumer side (drives in_*, sel_*, x_ready);
//        slave  = router side (drives in_ready, a_*/b_* streams, cnt_a, cnt_b, busy).
interface stream_demux2_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic              sel_b1;
  logic              sel_b2;
  logic [DATA_W-1:0] a_data;
  logic              a_last;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_data;
  logic              b_last;
  logic              b_valid;
  logic              b_ready;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic              busy;

  modport master (
    output in_data, in_last, in_valid, sel_b1, sel_b2, a_ready, b_ready,
    input  in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid, cnt_a, cnt_b, busy
  );

  modport slave (
    input  in_data, in_last, in_valid, sel_b1, sel_b2, a_ready, b_ready,
    output in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid, cnt_a, cnt_b, busy
  );
endinterface

// File: rtl/stream_demux2_out_stage.sv
// rtl/stream_demux2_out_stage.sv - one-entry registered output slice for one router port
// Purpose: holds one beat for a downstream consumer; data/last stay stable while stalled.
// Ports: clk, rst_n; load/in_data/in_last from the router; out_data/out_last/out_valid/out_ready
//        to the consumer; can_accept = stage empty or draining this cycle.
module out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  output logic              can_accept
);

  assign can_accept = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      // load is only raised when can_accept is true, so this also covers drain+reload
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - one-input, two-output packet router with per-packet route lock
// Purpose: steers each packet to port A or B based on sel sampled on its first beat,
//          registers both outputs, counts beats per port, reports busy.
// Ports: clk, rst_n (async active-low); bus (slave modport of stream_demux2_if).
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux2_if.slave  bus
);

  route_state_e     state;
  logic             a_can;
  logic             b_can;
  logic             to_b;
  logic             accept;
  logic             load_a;
  logic             load_b;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Route decision: locked while a packet is open, taken from sel only in IDLE.
  always_comb begin
    to_b = 1'b0;
    case (state)
      ROUTE_B: to_b = 1'b1;
      ROUTE_A: to_b = 1'b0;
      default: to_b = ({bus.sel_b1, bus.sel_b2} == SEL_B);
    endcase
  end

  // in_ready depends only on state, sel, stage valids and consumer readies, never on in_valid.
  assign bus.in_ready = to_b ? b_can : a_can;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_a       = accept && !to_b;
  assign load_b       = accept && to_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (load_a) cnt_a_q <= cnt_a_q + 1'b1;
      if (load_b) cnt_b_q <= cnt_b_q + 1'b1;
      case (state)
        IDLE:
          if (accept && !bus.in_last) state <= to_b ? ROUTE_B : ROUTE_A;
        ROUTE_A, ROUTE_B:
          if (accept && bus.in_last) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
  assign bus.busy  = (state != IDLE) || bus.a_valid || bus.b_valid;

  out_stage #(.DATA_W(DATA_W)) u_stage_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_a),
    .in_data    (bus.in_data),
    .in_last    (bus.in_last),
    .out_ready  (bus.a_ready),
    .out_data   (bus.a_data),
    .out_last   (bus.a_last),
    .out_valid  (bus.a_valid),
    .can_accept (a_can)
  );

  out_stage #(.DATA_W(DATA_W)) u_stage_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_b),
    .in_data    (bus.in_data),
    .in_last    (bus.in_last),
    .out_ready  (bus.b_ready),
    .out_data   (bus.b_data),
    .out_last   (bus.b_last),
    .out_valid  (bus.b_valid),
    .can_accept (b_can)
  );

endmodule

// File: tb/tb_stream_demux2.sv
// tb/tb_stream_demux2.sv - directed self-checking bench for stream_demux2
module tb_stream_demux2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  stream_demux2_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  stream_demux2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel_b1   = 1'b0;
    bus.sel_b2   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Present one beat, wait (bounded) for in_ready, accept on the next edge.
  task automatic send(input logic [7:0] d, input logic last, input logic s1, input logic s2);
    int waited;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.sel_b1   = s1;
    bus.sel_b2   = s2;
    bus.in_valid = 1'b1;
    #1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    do_reset();

    // reset values
    check("rst_a_valid", bus.a_valid, 0);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_a_data",  bus.a_data, 0);
    check("rst_b_data",  bus.b_data, 0);
    check("rst_lasts",   {bus.a_last, bus.b_last}, 0);
    check("rst_cnts",    {bus.cnt_a, bus.cnt_b}, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // single beat to B
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    send(8'h5A, 1'b1, 1'b1, 1'b1);
    check("single_b_valid", bus.b_valid, 1);
    check("single_b_data",  bus.b_data, 32'h5A);
    check("single_b_last",  bus.b_last, 1);
    check("single_a_valid", bus.a_valid, 0);
    check("single_cnt_b",   bus.cnt_b, 1);
    check("single_cnt_a",   bus.cnt_a, 0);
    step();
    check("single_drained_busy", bus.busy, 0);

    // packet lock: sel=00 on first beat, 11 afterwards, all to A
    send(8'h01, 1'b0, 1'b0, 1'b0);
    check("lock_a_data_1", bus.a_data, 32'h01);
    send(8'h02, 1'b0, 1'b1, 1'b1);
    check("lock_a_data_2", bus.a_data, 32'h02);
    check("lock_b_valid_2", bus.b_valid, 0);
    send(8'h03, 1'b0, 1'b1, 1'b1);
    check("lock_a_data_3", bus.a_data, 32'h03);
    send(8'h04, 1'b1, 1'b1, 1'b1);
    check("lock_a_data_4", bus.a_data, 32'h04);
    check("lock_a_last_4", bus.a_last, 1);
    check("lock_b_valid_4", bus.b_valid, 0);
    check("lock_cnt_a", bus.cnt_a, 4);
    check("lock_cnt_b", bus.cnt_b, 1);
    step();
    check("lock_idle_busy", bus.busy, 0);

    // backpressure on A
    bus.a_ready = 1'b0;
    send(8'h21, 1'b0, 1'b0, 1'b0);
    check("bp_a_data_first", bus.a_data, 32'h21);
    bus.in_data  = 8'h22;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", bus.in_ready, 0);
    step();
    step();
    check("bp_a_data_hold", bus.a_data, 32'h21);
    check("bp_a_valid_hold", bus.a_valid, 1);
    check("bp_busy", bus.busy, 1);
    bus.a_ready = 1'b1;
    #1;
    check("bp_in_ready_resume", bus.in_ready, 1);
    step();
    check("bp_a_data_22", bus.a_data, 32'h22);
    bus.in_data = 8'h23;
    bus.in_last = 1'b1;
    #1;
    check("bp_in_ready_stream", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_a_data_23", bus.a_data, 32'h23);
    check("bp_a_last_23", bus.a_last, 1);
    check("bp_cnt_a", bus.cnt_a, 7);
    step();
    check("bp_drained_valid", bus.a_valid, 0);

    // independent drain: A stalled, B packet proceeds
    bus.a_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0, 1'b0);
    check("ind_a_data", bus.a_data, 32'h11);
    send(8'h31, 1'b0, 1'b1, 1'b1);
    check("ind_b_data_31", bus.b_data, 32'h31);
    send(8'h32, 1'b1, 1'b0, 1'b0);
    check("ind_b_data_32", bus.b_data, 32'h32);
    check("ind_a_data_hold", bus.a_data, 32'h11);
    step();
    check("ind_b_valid_drained", bus.b_valid, 0);
    check("ind_busy_a_pending", bus.busy, 1);
    bus.a_ready = 1'b1;
    step();
    check("ind_a_valid_drained", bus.a_valid, 0);
    check("ind_busy_clear", bus.busy, 0);
    check("ind_cnt_a", bus.cnt_a, 8);
    check("ind_cnt_b", bus.cnt_b, 3);

    // counter wrap at CNT_W=4
    do_reset();
    check("wrap_rst_cnt_a", bus.cnt_a, 0);
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1, 1'b0, 1'b0);
      if (i == 14) check("wrap_cnt_15", bus.cnt_a, 15);
      if (i == 15) check("wrap_cnt_16", bus.cnt_a, 0);
    end
    check("wrap_cnt_17", bus.cnt_a, 1);
    check("wrap_cnt_b", bus.cnt_b, 0);
    step();

    // async reset mid-packet on B
    bus.b_ready = 1'b0;
    send(8'h41, 1'b0, 1'b1, 1'b1);
    check("ar_b_valid_pre", bus.b_valid, 1);
    check("ar_busy_pre", bus.busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_b_valid", bus.b_valid, 0);
    check("ar_b_data", bus.b_data, 0);
    check("ar_cnts", {bus.cnt_a, bus.cnt_b}, 0);
    check("ar_busy", bus.busy, 0);
    step();
    rst_n = 1'b1;
    #1;
    bus.a_ready = 1'b1;
    send(8'h42, 1'b1, 1'b0, 1'b0);
    check("ar_resample_a_valid", bus.a_valid, 1);
    check("ar_resample_a_data", bus.a_data, 32'h42);
    check("ar_resample_b_valid", bus.b_valid, 0);
    check("ar_resample_cnt_a", bus.cnt_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
